ising_l1_rd_arb: RTL and testbench

ISING_L1_RD_ARB -- requirements
Module: ising_l1_rd_arb

---
 rtl/ising_logic_pkg.sv | 12 +
 rtl/ising_l1_rd_tag_fifo.sv | 64 ++++++
 rtl/ising_l1_rd_arb.sv | 121 ++++++++++++
 tb/tb_ising_l1_rd_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_logic_pkg.sv
// Shared types and defaults for the Ising core logic blocks.
package ising_logic_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int DefaultNumReq         = 2;
    localparam int DefaultMaxOutstanding = 4;

endpackage

// File: rtl/ising_l1_rd_tag_fifo.sv
// In-order tag queue remembering which requester owns each outstanding read.
module ising_l1_rd_tag_fifo #(
    parameter int Width = 1,
    parameter int Depth = 4,
    localparam int PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [Width-1:0]      push_data,
    input  logic                  pop,
    output logic [Width-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [CountWidth-1:0] count
);

    logic [Width-1:0]      mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CountWidth-1:0] count_q;
    logic                  push_ok;
    logic                  pop_ok;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CountWidth'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only slots behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ising_l1_rd_arb.sv
// Read arbiter sharing one in-order memory port among several requesters.
module ising_l1_rd_arb
    import ising_logic_pkg::*;
#(
    parameter int NumReq         = DefaultNumReq,
    parameter int AddrWidth      = 16,
    parameter int DataWidth      = 256,
    parameter int MaxOutstanding = DefaultMaxOutstanding
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        arb_mode_i,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic [NumReq-1:0]           rsp_valid_o,
    output logic [DataWidth-1:0]        rsp_data_o,
    output logic                        mem_q_valid_o,
    output logic [AddrWidth-1:0]        mem_q_addr_o,
    input  logic                        mem_q_ready_i,
    input  logic                        mem_p_valid_i,
    input  logic [DataWidth-1:0]        mem_p_data_i,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int TagWidth   = $clog2(NumReq);
    localparam int CountWidth = $clog2(MaxOutstanding + 1);

    logic [NumReq-1:0]     eligible;
    logic [TagWidth-1:0]   winner;
    logic [TagWidth-1:0]   cand;
    logic                  any_eligible;
    logic                  accept;
    logic                  pop;
    logic [TagWidth-1:0]   rr_q;
    logic                  err_q;
    logic                  full;
    logic                  empty;
    logic [TagWidth-1:0]   head;
    logic [CountWidth-1:0] count;
    int                    start;
    int                    idx;

    assign eligible = req_valid_i & {NumReq{!full}};

    // Scan from the priority origin (0 in fixed mode, rr_q in round-robin) and take the first eligible.
    always_comb begin
        winner       = '0;
        cand         = '0;
        any_eligible = 1'b0;
        idx          = 0;
        start        = (arb_mode_e'(arb_mode_i) == ARB_RR) ? int'(rr_q) : 0;
        for (int i = 0; i < NumReq; i++) begin
            idx = start + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            cand = TagWidth'(idx);
            if (!any_eligible && eligible[cand]) begin
                winner       = cand;
                any_eligible = 1'b1;
            end
        end
    end

    assign mem_q_valid_o = any_eligible;
    assign mem_q_addr_o  = req_addr_i[int'(winner)*AddrWidth +: AddrWidth];
    assign accept        = any_eligible && mem_q_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (any_eligible) begin
            req_ready_o[winner] = mem_q_ready_i;
        end
    end

    assign pop        = mem_p_valid_i && !empty;
    assign rsp_data_o = mem_p_data_i;

    always_comb begin
        rsp_valid_o = '0;
        if (pop) begin
            rsp_valid_o[head] = 1'b1;
        end
    end

    // The pointer only moves on an accepted round-robin grant, so stalls and fixed mode leave it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept && (arb_mode_e'(arb_mode_i) == ARB_RR)) begin
                rr_q <= (winner == TagWidth'(NumReq - 1)) ? '0 : winner + 1'b1;
            end
            if (mem_p_valid_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o  = err_q;
    assign busy_o = (count != '0);

    ising_l1_rd_tag_fifo #(
        .Width (TagWidth),
        .Depth (MaxOutstanding)
    ) u_tag_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (accept),
        .push_data (winner),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_ising_l1_rd_arb.sv
// Directed self-checking bench for the L1 read arbiter (NumReq=2, MaxOutstanding=4).
module tb_ising_l1_rd_arb;

    logic         clk;
    logic         rst_n;
    logic         arb_mode;
    logic [1:0]   req_valid;
    logic [31:0]  req_addr;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [255:0] rsp_data;
    logic         mem_q_valid;
    logic [15:0]  mem_q_addr;
    logic         mem_q_ready;
    logic         mem_p_valid;
    logic [255:0] mem_p_data;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    ising_l1_rd_arb dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .arb_mode_i    (arb_mode),
        .req_valid_i   (req_valid),
        .req_addr_i    (req_addr),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (rsp_data),
        .mem_q_valid_o (mem_q_valid),
        .mem_q_addr_o  (mem_q_addr),
        .mem_q_ready_i (mem_q_ready),
        .mem_p_valid_i (mem_p_valid),
        .mem_p_data_i  (mem_p_data),
        .busy_o        (busy),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        arb_mode    = 1'b0;
        req_valid   = 2'b00;
        req_addr    = {16'h0020, 16'h0010};
        mem_q_ready = 1'b0;
        mem_p_valid = 1'b0;
        mem_p_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (mem_q_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_q_valid: got %b expected 0", mem_q_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_fixed_priority();
        arb_mode    = 1'b0;
        req_valid   = 2'b11;
        mem_q_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            checks++; if (mem_q_addr !== 16'h0010) begin errors++; $display("FAIL fixed_addr[%0d]: got %h expected 0010", c, mem_q_addr); end
            checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fixed_ready[%0d]: got %b expected 01", c, req_ready); end
            next_cycle();
        end
        req_valid   = 2'b00;
        mem_p_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mem_p_data = 256'hA0 + 256'(c);
            #3;
            checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL fixed_rsp_valid[%0d]: got %b expected 01", c, rsp_valid); end
            checks++; if (rsp_data !== 256'hA0 + 256'(c)) begin errors++; $display("FAIL fixed_rsp_data[%0d]: got %h expected %h", c, rsp_data[15:0], 16'hA0 + 16'(c)); end
            next_cycle();
        end
        mem_p_valid = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fixed_busy_after: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fixed_err_after: got %b expected 0", err); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [15:0] exp_addr  [4] = '{16'h0010, 16'h0020, 16'h0010, 16'h0020};
        arb_mode    = 1'b1;
        req_valid   = 2'b11;
        mem_q_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #3;
            checks++; if (req_ready !== exp_ready[c]) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, exp_ready[c]); end
            checks++; if (mem_q_addr !== exp_addr[c]) begin errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", c, mem_q_addr, exp_addr[c]); end
            next_cycle();
        end
        req_valid = 2'b00;
        #3;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy: got %b expected 1", busy); end
        next_cycle();
        mem_p_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_p_data = 256'hB0 + 256'(c);
            #3;
            checks++; if (rsp_valid !== exp_ready[c]) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, exp_ready[c]); end
            next_cycle();
        end
        mem_p_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_full();
        arb_mode    = 1'b0;
        req_valid   = 2'b01;
        mem_q_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #3;
            checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL full_fill_ready[%0d]: got %b expected 01", c, req_ready); end
            next_cycle();
        end
        #3;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_blocked_ready: got %b expected 00", req_ready); end
        checks++; if (mem_q_valid !== 1'b0) begin errors++; $display("FAIL full_blocked_q_valid: got %b expected 0", mem_q_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", busy); end
        next_cycle();
        mem_p_valid = 1'b1;
        mem_p_data  = 256'hC0;
        #3;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_pop_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL full_pop_rsp: got %b expected 01", rsp_valid); end
        next_cycle();
        mem_p_valid = 1'b0;
        #3;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL full_freed_ready: got %b expected 01", req_ready); end
        next_cycle();
        #3;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_refull_ready: got %b expected 00", req_ready); end
        req_valid   = 2'b00;
        mem_p_valid = 1'b1;
        next_cycle();
        repeat (3) next_cycle();
        mem_p_valid = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drained_busy: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_drained_err: got %b expected 0", err); end
        next_cycle();
    endtask

    task automatic test_response_order();
        logic [1:0]   pattern   [3] = '{2'b10, 2'b01, 2'b10};
        logic [255:0] resp_data [3] = '{256'hD0, 256'hD1, 256'hD2};
        arb_mode    = 1'b0;
        mem_q_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_valid = pattern[c];
            #3;
            checks++; if (req_ready !== pattern[c]) begin errors++; $display("FAIL order_grant[%0d]: got %b expected %b", c, req_ready, pattern[c]); end
            next_cycle();
        end
        req_valid   = 2'b00;
        mem_p_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mem_p_data = resp_data[c];
            #3;
            checks++; if (rsp_valid !== pattern[c]) begin errors++; $display("FAIL order_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, pattern[c]); end
            checks++; if (rsp_data !== resp_data[c]) begin errors++; $display("FAIL order_rsp_data[%0d]: got %h expected %h", c, rsp_data[15:0], resp_data[c][15:0]); end
            next_cycle();
        end
        mem_p_valid = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL order_busy: got %b expected 0", busy); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        arb_mode    = 1'b0;
        mem_q_ready = 1'b1;
        req_valid   = 2'b10;
        next_cycle();
        req_valid   = 2'b01;
        mem_p_valid = 1'b1;
        mem_p_data  = 256'hE0;
        #3;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL b2b_rsp0: got %b expected 10", rsp_valid); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_push: got %b expected 01", req_ready); end
        next_cycle();
        req_valid  = 2'b00;
        mem_p_data = 256'hE1;
        #3;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL b2b_rsp1: got %b expected 01", rsp_valid); end
        next_cycle();
        mem_p_valid = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after: got %b expected 0", busy); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        arb_mode    = 1'b1;
        req_valid   = 2'b01;
        mem_q_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #3;
            checks++; if (mem_q_valid !== 1'b1) begin errors++; $display("FAIL bp_q_valid[%0d]: got %b expected 1", c, mem_q_valid); end
            checks++; if (mem_q_addr !== 16'h0010) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected 0010", c, mem_q_addr); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", c, req_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_push[%0d]: got %b expected 0", c, busy); end
            next_cycle();
        end
        req_valid   = 2'b11;
        mem_q_ready = 1'b1;
        #3;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_rr_held: got %b expected 01", req_ready); end
        next_cycle();
        #3;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_rr_advanced: got %b expected 10", req_ready); end
        arb_mode = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mode_to_fixed: got %b expected 01", req_ready); end
        arb_mode = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL mode_back_rr: got %b expected 10", req_ready); end
        req_valid = 2'b00;
        arb_mode  = 1'b0;
        next_cycle();
        mem_p_valid = 1'b1;
        #3;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_drain: got %b expected 01", rsp_valid); end
        next_cycle();
        mem_p_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_error();
        req_valid   = 2'b01;
        mem_q_ready = 1'b1;
        next_cycle();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_reset_discard: got %b expected 0", busy); end
        rst_n = 1'b1;
        next_cycle();
        mem_p_valid = 1'b1;
        #3;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL err_no_rsp: got %b expected 00", rsp_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before_edge: got %b expected 0", err); end
        next_cycle();
        mem_p_valid = 1'b0;
        #3;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_count_kept: got %b expected 0", busy); end
        repeat (2) next_cycle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
        rst_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", err); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_full();
        test_response_order();
        test_back_to_back();
        test_backpressure();
        test_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
